// File: rtl/amp_boot_i2c.sv
// amp_boot_i2c: on an amp_init rising edge, latch the eight boot bytes and write them
// to the amplifier as one I2C write transaction over open-drain SCL/SDA pads.
module amp_boot_i2c #(
    parameter int         CLK_DIV  = 30,
    parameter logic [6:0] DEV_ADDR = 7'h2C
) (
    input  logic        clk,
    input  logic        resetb,
    input  logic        amp_init,
    input  logic [63:0] bootmem,
    input  logic        sda_in,
    output logic        scl_oe,
    output logic        sda_oe,
    output logic [7:0]  status,
    output logic        busy
);
    localparam logic [9:0] QMAX = 10'(CLK_DIV - 1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_BYTE, S_ACK, S_STOP} state_t;
    state_t r_state, w_next;

    logic [9:0]  r_qcnt;
    logic [1:0]  r_phase;
    logic [2:0]  r_bit;
    logic [3:0]  r_idx;
    logic [7:0]  r_byte;
    logic [63:0] r_buf;
    logic        r_init_prev;
    logic        r_ack_bit;
    logic        r_done;
    logic        r_nack;
    logic [3:0]  r_nidx;
    logic        w_trig;
    logic        w_qwrap;
    logic        w_bit_end;

    assign w_trig    = amp_init && !r_init_prev && (r_state == S_IDLE);
    assign w_qwrap   = (r_qcnt == QMAX);
    assign w_bit_end = w_qwrap && (r_phase == 2'd3);

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) r_state <= S_IDLE;
        else         r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_trig) w_next = S_START;
            S_START: if (w_bit_end) w_next = S_BYTE;
            S_BYTE:  if (w_bit_end && r_bit == 3'd7) w_next = S_ACK;
            S_ACK: begin
                if (w_bit_end) begin
                    if (r_ack_bit || r_idx == 4'd8) w_next = S_STOP;
                    else                            w_next = S_BYTE;
                end
            end
            S_STOP:  if (w_bit_end) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            r_init_prev <= 1'b0;
            r_qcnt      <= '0;
            r_phase     <= '0;
            r_bit       <= '0;
            r_idx       <= '0;
            r_byte      <= '0;
            r_buf       <= '0;
            r_ack_bit   <= 1'b0;
            r_done      <= 1'b0;
            r_nack      <= 1'b0;
            r_nidx      <= '0;
        end else begin
            r_init_prev <= amp_init;
            if (w_trig) begin
                r_buf   <= bootmem;
                r_byte  <= {DEV_ADDR, 1'b0};
                r_idx   <= '0;
                r_bit   <= '0;
                r_qcnt  <= '0;
                r_phase <= '0;
                r_done  <= 1'b0;
                r_nack  <= 1'b0;
                r_nidx  <= '0;
            end else if (r_state != S_IDLE) begin
                r_qcnt <= w_qwrap ? '0 : r_qcnt + 10'd1;
                if (w_qwrap) r_phase <= r_phase + 2'd1;
                // Slave ACK is sampled on the last cycle of q2, while SCL is high.
                if (r_state == S_ACK && r_phase == 2'd2 && w_qwrap) r_ack_bit <= sda_in;
                if (r_state == S_BYTE && w_bit_end) begin
                    r_byte <= {r_byte[6:0], 1'b0};
                    r_bit  <= r_bit + 3'd1;
                end
                if (r_state == S_ACK && w_bit_end) begin
                    if (r_ack_bit) begin
                        r_nack <= 1'b1;
                        r_nidx <= r_idx;
                    end else if (r_idx != 4'd8) begin
                        r_byte <= r_buf[7:0];
                        r_buf  <= {8'h00, r_buf[63:8]};
                        r_idx  <= r_idx + 4'd1;
                    end
                end
                if (r_state == S_STOP && w_bit_end) r_done <= !r_nack;
            end
        end
    end

    // Pad drive decodes straight from reset registers so a reset releases both lines at once.
    always_comb begin
        scl_oe = 1'b0;
        sda_oe = 1'b0;
        case (r_state)
            S_START: sda_oe = r_phase[1];
            S_BYTE: begin
                scl_oe = !r_phase[1];
                sda_oe = !r_byte[7];
            end
            S_ACK:   scl_oe = !r_phase[1];
            S_STOP: begin
                scl_oe = !r_phase[1];
                sda_oe = (r_phase != 2'd3);
            end
            default: ;
        endcase
    end

    assign busy   = (r_state != S_IDLE);
    assign status = {1'b0, r_nidx, r_nack, r_done, busy};

endmodule

// File: tb/tb_amp_boot_i2c.sv
// Bench for amp_boot_i2c: I2C bus monitor plus ACK/NACK slave, with expected bus events queued per transaction.
module tb_amp_boot_i2c;
    logic        clk = 1'b0;
    logic        resetb;
    logic        amp_init;
    logic [63:0] bootmem;
    logic        sda_in;
    logic        scl_oe;
    logic        sda_oe;
    logic [7:0]  status;
    logic        busy;

    logic        slave_pull = 1'b0;
    logic        mon_en = 1'b0;
    int          nack_at_g = -1;
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [10:0] exp_q[$];

    logic        scl_prev = 1'b1;
    logic        sda_prev = 1'b1;
    int          m_bits = 0;
    int          m_bytes = 0;
    logic [7:0]  m_sr = '0;

    typedef struct {
        logic [63:0] bm;
        int          nack_at;
        logic [7:0]  st;
        int          len;
    } vec_t;
    vec_t vecs[5];

    assign sda_in = !(sda_oe || slave_pull);

    amp_boot_i2c #(.CLK_DIV(4), .DEV_ADDR(7'h2C)) dut (
        .clk      (clk),
        .resetb   (resetb),
        .amp_init (amp_init),
        .bootmem  (bootmem),
        .sda_in   (sda_in),
        .scl_oe   (scl_oe),
        .sda_oe   (sda_oe),
        .status   (status),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic see_evt(input logic [10:0] ev);
        logic [10:0] e;
        if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL bus_event: got %0h expected none", ev);
        end else begin
            e = exp_q.pop_front();
            chk("bus_event", 64'(ev), 64'(e));
        end
    endtask

    // Event encoding: {kind, ack_bit, data}; kind 0=START, 1=STOP, 2=byte; ack_bit 1 = NACK.
    always @(negedge clk) begin
        logic scl_now;
        logic sda_now;
        scl_now = !scl_oe;
        sda_now = sda_in;
        if (!mon_en) begin
            m_bits     = 0;
            m_bytes    = 0;
            slave_pull = 1'b0;
        end else if (scl_prev && scl_now && sda_prev && !sda_now) begin
            see_evt({2'd0, 1'b0, 8'h00});
            m_bits  = 0;
            m_bytes = 0;
        end else if (scl_prev && scl_now && !sda_prev && sda_now) begin
            see_evt({2'd1, 1'b0, 8'h00});
            m_bits = 0;
        end else if (!scl_prev && scl_now) begin
            if (m_bits < 8) begin
                m_sr   = {m_sr[6:0], sda_now};
                m_bits = m_bits + 1;
            end else begin
                see_evt({2'd2, sda_now, m_sr});
                m_bits  = 0;
                m_bytes = m_bytes + 1;
            end
        end else if (scl_prev && !scl_now) begin
            slave_pull = (m_bits == 8) && (m_bytes != nack_at_g);
        end
        scl_prev = scl_now;
        sda_prev = sda_now;
    end

    task automatic push_expected(input logic [63:0] bm, input int nack_at);
        exp_q.push_back({2'd0, 1'b0, 8'h00});
        exp_q.push_back({2'd2, nack_at == 0, 8'h58});
        for (int k = 0; k < 8; k++) begin
            if (nack_at < 0 || nack_at > k)
                exp_q.push_back({2'd2, nack_at == k + 1, bm[k*8 +: 8]});
        end
        exp_q.push_back({2'd1, 1'b0, 8'h00});
    endtask

    task automatic wait_idle(output int cnt);
        cnt = 0;
        while (busy && cnt < 5000) begin
            cnt++;
            @(negedge clk);
        end
    endtask

    task automatic run_txn(input logic [63:0] bm, input int nack_at,
                           input logic [7:0] st, input int len);
        int cnt;
        nack_at_g = nack_at;
        bootmem   = bm;
        push_expected(bm, nack_at);
        @(negedge clk) amp_init = 1'b1;
        @(negedge clk) amp_init = 1'b0;
        chk("status_at_start", 64'(status), 64'h01);
        wait_idle(cnt);
        chk("busy_length", 64'(cnt), 64'(len));
        repeat (4) @(negedge clk);
        chk("final_status", 64'(status), 64'(st));
        chk("events_left", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        int cnt;
        vecs[0] = '{64'h0706050403020100, -1, 8'h02, 1328};
        vecs[1] = '{64'h0706050403020100,  0, 8'h04, 176};
        vecs[2] = '{64'h0706050403020100,  4, 8'h24, 752};
        vecs[3] = '{64'hA55AF00F0123CDEF, -1, 8'h02, 1328};
        vecs[4] = '{64'h80FF7F01C33C5AA5,  8, 8'h44, 1328};

        resetb   = 1'b0;
        amp_init = 1'b0;
        bootmem  = '0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk) amp_init = ~amp_init;
            #1 chk("reset_outputs", {54'd0, scl_oe, sda_oe, status}, 64'd0);
        end
        @(negedge clk) amp_init = 1'b0;
        @(negedge clk) resetb = 1'b1;
        mon_en = 1'b1;
        repeat (3) @(negedge clk);

        for (int v = 0; v < 5; v++)
            run_txn(vecs[v].bm, vecs[v].nack_at, vecs[v].st, vecs[v].len);

        // bootmem change and amp_init held high during byte 2: neither may disturb or retrigger
        nack_at_g = -1;
        bootmem   = 64'h1122334455667788;
        push_expected(bootmem, -1);
        @(negedge clk) amp_init = 1'b1;
        @(negedge clk) amp_init = 1'b0;
        cnt = 0;
        while (m_bytes != 2 && cnt < 2000) begin
            cnt++;
            @(negedge clk);
        end
        chk("reach_byte2", 64'(cnt < 2000), 64'd1);
        bootmem  = '1;
        amp_init = 1'b1;
        wait_idle(cnt);
        chk("busy_fell", 64'(busy), 64'd0);
        chk("mid_status", 64'(status), 64'h02);
        repeat (20) @(negedge clk);
        chk("no_retrigger", 64'(busy), 64'd0);
        chk("mid_events_left", 64'(exp_q.size()), 64'd0);
        amp_init = 1'b0;
        @(negedge clk);
        run_txn(64'h0706050403020100, -1, 8'h02, 1328);

        // Reset while a data byte is pulling SDA low
        nack_at_g = -1;
        bootmem   = 64'h0706050403020100;
        push_expected(bootmem, -1);
        @(negedge clk) amp_init = 1'b1;
        @(negedge clk) amp_init = 1'b0;
        cnt = 0;
        while (!(m_bytes == 1 && sda_oe) && cnt < 2000) begin
            cnt++;
            @(negedge clk);
        end
        chk("reach_data_byte", 64'(cnt < 2000), 64'd1);
        mon_en = 1'b0;
        resetb = 1'b0;
        #1;
        chk("rst_scl_oe", 64'(scl_oe), 64'd0);
        chk("rst_sda_oe", 64'(sda_oe), 64'd0);
        chk("rst_status", 64'(status), 64'h00);
        exp_q.delete();
        repeat (3) @(negedge clk);
        resetb = 1'b1;
        @(negedge clk);
        mon_en = 1'b1;
        repeat (2) @(negedge clk);
        run_txn(64'h0706050403020100, -1, 8'h02, 1328);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
